// File: rtl/operand_collector.sv
// ----------------------------------------------------------------------------
// operand_collector
//
// Collects the source operands of one decoded instruction from a single
// register-file bank and hands the complete set to the dispatch stage.
// One instruction is held at a time. Reads go out one per cycle on the bank
// read port. Read data comes back one cycle after the request is accepted and
// is stored into the operand slot that issued it.
//
// Configuration macro: OPERAND_COLLECTOR_DEDUP_EN
//   When defined, operands that repeat the address of a lower-index used
//   operand become aliases. They issue no read of their own, and the
//   lower-index response is also written into them.
//   When undefined, every used operand issues its own read.
//
// Ports
//   clk_i, rst_i        clock (rising edge); asynchronous active-high reset
//   instr_valid_i/ready_o, instr_tag_i, instr_op_used_i, instr_op_addr_i
//                       instruction intake (address of operand i in slice i)
//   rf_read_valid_o/ready_i, rf_read_addr_o
//                       read request to the bank
//   rf_rsp_valid_i, rf_rsp_addr_i, rf_rsp_data_i
//                       bank read response (cycle after accepted request)
//   disp_valid_o/ready_i, disp_tag_o, disp_operands_o
//                       complete operand set to dispatch (unused slots are 0)
// ----------------------------------------------------------------------------
module operand_collector #(
    parameter int  DataWidth    = 32,
    parameter int  NumRegisters = 32,
    parameter int  NumOperands  = 3,
    parameter int  TagWidth     = 8,
    localparam int AddrW        = $clog2(NumRegisters)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             instr_valid_i,
    output logic                             instr_ready_o,
    input  logic [TagWidth-1:0]              instr_tag_i,
    input  logic [NumOperands-1:0]           instr_op_used_i,
    input  logic [NumOperands*AddrW-1:0]     instr_op_addr_i,
    output logic                             rf_read_valid_o,
    input  logic                             rf_read_ready_i,
    output logic [AddrW-1:0]                 rf_read_addr_o,
    input  logic                             rf_rsp_valid_i,
    input  logic [AddrW-1:0]                 rf_rsp_addr_i,
    input  logic [DataWidth-1:0]             rf_rsp_data_i,
    output logic                             disp_valid_o,
    input  logic                             disp_ready_i,
    output logic [TagWidth-1:0]              disp_tag_o,
    output logic [NumOperands*DataWidth-1:0] disp_operands_o
);

    localparam int IdxW = (NumOperands > 1) ? $clog2(NumOperands) : 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_READ     = 2'd1,
        S_WAIT     = 2'd2,
        S_DISPATCH = 2'd3
    } state_e;

    state_e                           state_q, state_d;
    logic [TagWidth-1:0]              tag_q, tag_d;
    logic [NumOperands*AddrW-1:0]     addr_q, addr_d;
    logic [NumOperands-1:0]           pending_q, pending_d;
    logic [NumOperands*DataWidth-1:0] opnd_q, opnd_d;
    logic                             inflight_q, inflight_d;
    logic [IdxW-1:0]                  inflight_idx_q, inflight_idx_d;
    logic [AddrW-1:0]                 inflight_addr_q, inflight_addr_d;

    logic                             accept_s;
    logic                             issue_s;
    logic                             rsp_take_s;
    logic [IdxW-1:0]                  sel_idx_s;
    logic [AddrW-1:0]                 sel_addr_s;
    logic [NumOperands-1:0]           accept_pending_s;
    logic [NumOperands-1:0]           wr_mask_s;

    assign accept_s   = (state_q == S_IDLE) && instr_valid_i;
    assign issue_s    = (state_q == S_READ) && rf_read_ready_i;
    assign rsp_take_s = rf_rsp_valid_i && inflight_q;

`ifdef OPERAND_COLLECTOR_DEDUP_EN
    logic [NumOperands-1:0]      used_q, used_d;
    logic [NumOperands*IdxW-1:0] leader_q, leader_d;
    logic [NumOperands*IdxW-1:0] new_leader_s;

    // Leader of operand i = lowest-index used operand with the same address
    // (itself if none). Only leaders go pending; the others are aliases.
    always_comb begin
        new_leader_s     = '0;
        accept_pending_s = '0;
        for (int i = 0; i < NumOperands; i++) begin
            new_leader_s[i*IdxW +: IdxW] = IdxW'(i);
            for (int j = i - 1; j >= 0; j--) begin
                new_leader_s[i*IdxW +: IdxW] =
                    (instr_op_used_i[j] &&
                     (instr_op_addr_i[j*AddrW +: AddrW] == instr_op_addr_i[i*AddrW +: AddrW]))
                    ? IdxW'(j) : new_leader_s[i*IdxW +: IdxW];
            end
            accept_pending_s[i] = instr_op_used_i[i] &&
                                  (new_leader_s[i*IdxW +: IdxW] == IdxW'(i));
        end
    end

    // Alias bookkeeping is captured together with the instruction.
    always_comb begin
        if (accept_s) begin
            used_d   = instr_op_used_i;
            leader_d = new_leader_s;
        end else begin
            used_d   = used_q;
            leader_d = leader_q;
        end
    end

    // Alias bookkeeping registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            used_q   <= '0;
            leader_q <= '0;
        end else begin
            used_q   <= used_d;
            leader_q <= leader_d;
        end
    end

    // A response lands in its own slot and in every alias that follows it.
    always_comb begin
        wr_mask_s = '0;
        for (int i = 0; i < NumOperands; i++) begin
            wr_mask_s[i] = used_q[i] && (leader_q[i*IdxW +: IdxW] == inflight_idx_q);
        end
    end
`else
    assign accept_pending_s = instr_op_used_i;

    // A response lands only in the slot that issued it.
    always_comb begin
        wr_mask_s = '0;
        for (int i = 0; i < NumOperands; i++) begin
            wr_mask_s[i] = (IdxW'(i) == inflight_idx_q);
        end
    end
`endif

    // Priority pick of the lowest-index pending operand.
    always_comb begin
        sel_idx_s = '0;
        for (int i = NumOperands - 1; i >= 0; i--) begin
            sel_idx_s = pending_q[i] ? IdxW'(i) : sel_idx_s;
        end
        sel_addr_s = addr_q[sel_idx_s*AddrW +: AddrW];
    end

    // Next-state and datapath updates. Defaults are assigned first.
    always_comb begin
        state_d         = state_q;
        tag_d           = tag_q;
        addr_d          = addr_q;
        pending_d       = pending_q;
        opnd_d          = opnd_q;
        inflight_d      = inflight_q;
        inflight_idx_d  = inflight_idx_q;
        inflight_addr_d = inflight_addr_q;

        // The response to the previous request is retired first. An issue in
        // the same cycle then re-arms the in-flight flag for the new request.
        if (rsp_take_s) begin
            inflight_d = 1'b0;
            for (int i = 0; i < NumOperands; i++) begin
                if (wr_mask_s[i]) begin
                    opnd_d[i*DataWidth +: DataWidth] = rf_rsp_data_i;
                end else begin
                    opnd_d[i*DataWidth +: DataWidth] = opnd_d[i*DataWidth +: DataWidth];
                end
            end
        end else begin
            inflight_d = inflight_q;
        end

        if (issue_s) begin
            pending_d[sel_idx_s] = 1'b0;
            inflight_d           = 1'b1;
            inflight_idx_d       = sel_idx_s;
            inflight_addr_d      = sel_addr_s;
        end else begin
            pending_d = pending_d;
        end

        case (state_q)
            S_IDLE: begin
                if (instr_valid_i) begin
                    tag_d     = instr_tag_i;
                    addr_d    = instr_op_addr_i;
                    pending_d = accept_pending_s;
                    opnd_d    = '0;
                    state_d   = (accept_pending_s == '0) ? S_DISPATCH : S_READ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (issue_s && (pending_d == '0)) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_READ;
                end
            end
            S_WAIT: begin
                if (rsp_take_s) begin
                    state_d = S_DISPATCH;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DISPATCH: begin
                if (disp_ready_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DISPATCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= S_IDLE;
            tag_q           <= '0;
            addr_q          <= '0;
            pending_q       <= '0;
            opnd_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_idx_q  <= '0;
            inflight_addr_q <= '0;
        end else begin
            state_q         <= state_d;
            tag_q           <= tag_d;
            addr_q          <= addr_d;
            pending_q       <= pending_d;
            opnd_q          <= opnd_d;
            inflight_q      <= inflight_d;
            inflight_idx_q  <= inflight_idx_d;
            inflight_addr_q <= inflight_addr_d;
        end
    end

    assign instr_ready_o   = (state_q == S_IDLE);
    assign rf_read_valid_o = (state_q == S_READ);
    assign rf_read_addr_o  = (state_q == S_READ) ? sel_addr_s : '0;
    assign disp_valid_o    = (state_q == S_DISPATCH);
    assign disp_tag_o      = tag_q;
    assign disp_operands_o = opnd_q;

    operand_collector_checker #(
        .AddrW       (AddrW),
        .IdxW        (IdxW),
        .NumOperands (NumOperands)
    ) u_checker (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .rsp_valid_i     (rf_rsp_valid_i),
        .rsp_addr_i      (rf_rsp_addr_i),
        .inflight_i      (inflight_q),
        .inflight_addr_i (inflight_addr_q),
        .inflight_idx_i  (inflight_idx_q)
    );

endmodule

// ----------------------------------------------------------------------------
// operand_collector_checker
//
// Simulation-only properties of the collector.
// - Every stored response must echo the address of the request in flight.
// - The in-flight index must name a real operand.
// - The index width must be $clog2(NumOperands), with a minimum of 1.
// Ports: clock, reset, the response valid and address, and the in-flight
// flag, address and index.
// ----------------------------------------------------------------------------
module operand_collector_checker #(
    parameter int AddrW       = 5,
    parameter int IdxW        = 2,
    parameter int NumOperands = 3
) (
    input logic             clk_i,
    input logic             rst_i,
    input logic             rsp_valid_i,
    input logic [AddrW-1:0] rsp_addr_i,
    input logic             inflight_i,
    input logic [AddrW-1:0] inflight_addr_i,
    input logic [IdxW-1:0]  inflight_idx_i
);

    localparam int ExpIdxW = (NumOperands > 1) ? $clog2(NumOperands) : 1;

    a_rsp_addr_match: assert property (@(posedge clk_i) disable iff (rst_i)
        (rsp_valid_i && inflight_i) |-> (rsp_addr_i == inflight_addr_i));

    a_idx_in_range: assert property (@(posedge clk_i) disable iff (rst_i)
        inflight_i |-> (int'(inflight_idx_i) < NumOperands));

    a_idx_width: assert property (@(posedge clk_i)
        (IdxW == ExpIdxW) && (IdxW >= 1));

endmodule
